fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: fetches from pc, issues one instruction at a time, retires on core_done.
// Optional fetch watchdog compiled in with macro FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [15:0]          HALT_INSTR = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_valid,
    output logic [15:0]         instruction,
    output logic                instr_valid,
    input  logic                core_done,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic [15:0]         fetch_count,
    output logic                timeout_err,
    output logic [2:0]          dbg_state
);

    // Handshakes: mem_req is held for the whole FETCH state and a read completes on the
    // first edge where mem_req && mem_valid; instr_valid is a one-cycle, non-stalling issue
    // pulse; core_done acknowledges the issued instruction and is only sampled in EXEC.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]           instr_q, instr_d;
    logic [15:0]           count_q, count_d;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]            wdog_q, wdog_d;
    logic                  timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
`ifdef FETCH_TIMEOUT_EN
        // Leaving FETCH clears the watchdog, so every FETCH entry starts from zero.
        wdog_d    = 8'd0;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    state_d = (mem_rdata == HALT_INSTR) ? S_HALT : S_ISSUE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_d == 8'hFF) begin
                        timeout_d = 1'b1;
                        state_d   = S_HALT;
                    end
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (core_done) begin
                    pc_d    = pc_q + PC_ONE;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req     = (state_q == S_FETCH);
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (PC_WIDTH=4): vector table plus hand-written corner sequences.
module tb_fetch_sequencer;

  localparam int PW = 4;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          mem_req;
  logic [PW-1:0] mem_addr;
  logic [15:0]   mem_rdata;
  logic          mem_valid;
  logic [15:0]   instruction;
  logic          instr_valid;
  logic          core_done;
  logic [PW-1:0] pc;
  logic          halted;
  logic [15:0]   fetch_count;
  logic          timeout_err;
  logic [2:0]    dbg_state;

  fetch_sequencer #(
    .PC_WIDTH   (PW),
    .RESET_PC   (4'd0),
    .HALT_INSTR (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .core_done   (core_done),
    .pc          (pc),
    .halted      (halted),
    .fetch_count (fetch_count),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  typedef struct {
    logic [15:0]   rdata;
    int            mem_delay;
    int            done_wait;
    logic          run_after;
    logic [PW-1:0] exp_pc;
    logic [15:0]   exp_count;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard: every issue pulse must match the oldest fetched instruction
  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_issue", {31'b0, instr_valid}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("issued_instr", {16'b0, instruction}, {16'b0, mon_exp});
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    mem_valid = 1'b0;
    core_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // one instruction, starting at a negedge with the DUT in FETCH
  task automatic run_instr(input vec_t v, input logic [PW-1:0] cur_pc);
    check("fetch_state", dbg_state, S_FETCH);
    check("mem_req_fetch", mem_req, 1);
    check("mem_addr", mem_addr, cur_pc);
    for (int c = 0; c < v.mem_delay; c++) begin
      core_done = 1'b1;
      @(negedge clk);
    end
    core_done = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = v.rdata;
    exp_q.push_back(v.rdata);
    @(negedge clk);
    mem_valid = 1'b0;
    check("issue_state", dbg_state, S_ISSUE);
    check("issue_pulse", instr_valid, 1);
    check("mem_req_issue", mem_req, 0);
    run = v.run_after;
    @(negedge clk);
    check("pulse_width", instr_valid, 0);
    for (int c = 0; c < v.done_wait; c++) begin
      mem_valid = 1'b1;
      mem_rdata = ~v.rdata;
      @(negedge clk);
    end
    mem_valid = 1'b0;
    check("exec_state", dbg_state, S_EXEC);
    check("instr_stable", instruction, v.rdata);
    check("pc_hold", pc, cur_pc);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("pc_after", pc, v.exp_pc);
    check("count_after", fetch_count, v.exp_count);
    check("state_after", dbg_state, v.run_after ? S_FETCH : S_IDLE);
  endtask

  initial begin
    vec_t v;
    reset     = 1'b1;
    run       = 1'b1;
    mem_valid = 1'b1;
    core_done = 1'b1;
    mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 0);
    check("rst_count", fetch_count, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout_err, 0);
    do_reset();

    // idle holds without run, ignoring stray core_done / mem_valid
    core_done = 1'b1;
    mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    core_done = 1'b0;
    mem_valid = 1'b0;
    check("idle_hold", dbg_state, S_IDLE);
    check("idle_mem_req", mem_req, 0);
    check("idle_pc", pc, 0);

    for (int i = 0; i < 16; i++) begin
      vecs[i].rdata     = 16'($urandom_range(0, 16'hFFFE));
      vecs[i].mem_delay = $urandom_range(0, 3);
      vecs[i].done_wait = $urandom_range(0, 3);
      vecs[i].run_after = (i != 7);
      vecs[i].exp_pc    = PW'(i + 1);
      vecs[i].exp_count = 16'(i + 1);
    end
    vecs[0].rdata     = 16'h1234;
    vecs[0].mem_delay = 2;
    vecs[0].done_wait = 2;

    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i], PW'(i));
      if (!vecs[i].run_after) begin
        repeat (3) begin
          @(negedge clk);
          check("stopped_idle", dbg_state, S_IDLE);
          check("stopped_mem_req", mem_req, 0);
        end
        run = 1'b1;
        @(negedge clk);
      end
    end
    check("wrap_pc", pc, 0);
    check("wrap_count", fetch_count, 16);

    v = '{16'h0A0A, 1, 1, 1'b1, 4'd1, 16'd17};
    run_instr(v, 4'd0);
    v = '{16'h5555, 0, 0, 1'b1, 4'd2, 16'd18};
    run_instr(v, 4'd1);

    // halt fetch at pc=2
    mem_valid = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_valid = 1'b0;
    check("halt_flag", halted, 1);
    check("halt_state", dbg_state, S_HALT);
    check("halt_pc", pc, 2);
    check("halt_count", fetch_count, 18);
    check("halt_no_issue", instr_valid, 0);
    check("halt_instr", instruction, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      run       = 1'($urandom_range(0, 1));
      core_done = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom_range(0, 16'hFFFE));
      @(negedge clk);
      check("halt_sticky", halted, 1);
    end
    check("halt_pc_kept", pc, 2);
    check("halt_count_kept", fetch_count, 18);
    check("halt_mem_req", mem_req, 0);
    do_reset();
    check("unhalt_state", dbg_state, S_IDLE);
    check("unhalt_flag", halted, 0);
    check("unhalt_pc", pc, 0);

    // reset wins over core_done in EXEC
    run = 1'b1;
    @(negedge clk);
    v = '{16'h1111, 0, 0, 1'b1, 4'd1, 16'd1};
    run_instr(v, 4'd0);
    mem_valid = 1'b1;
    mem_rdata = 16'h2222;
    exp_q.push_back(16'h2222);
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_exec", dbg_state, S_EXEC);
    reset     = 1'b1;
    core_done = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    core_done = 1'b0;
    run       = 1'b0;
    check("exec_rst_pc", pc, 0);
    check("exec_rst_count", fetch_count, 0);
    check("exec_rst_state", dbg_state, S_IDLE);
    check("exec_rst_instr", instruction, 0);

    // fetch with no memory response
    run = 1'b1;
    @(negedge clk);
    check("wd_fetch", dbg_state, S_FETCH);
`ifdef FETCH_TIMEOUT_EN
    repeat (254) @(negedge clk);
    check("wd_not_yet", dbg_state, S_FETCH);
    check("wd_not_yet_err", timeout_err, 0);
    @(negedge clk);
    check("wd_timeout", timeout_err, 1);
    check("wd_halted", halted, 1);
`else
    repeat (300) @(negedge clk);
    check("wd_still_fetch", dbg_state, S_FETCH);
    check("wd_mem_req", mem_req, 1);
    check("wd_no_err", timeout_err, 0);
`endif
    do_reset();
    check("final_rst_err", timeout_err, 0);
    check("final_rst_state", dbg_state, S_IDLE);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
